clk_div_multi: RTL and testbench
================================

# clk_div_multi

Multi-channel programmable clock/pulse generator for the ultrasonic and peripheral subsystem. Each of CHANNELS channels produces a registered divided clock with programmable period and high time, either continuously or as a counted burst, e.g. a 40 kHz 8-cycle transducer burst or a trigger pulse. Configuration is written per channel through a simple write strobe. Updates to a running channel are glitch-free, applied only at a period boundary.

## Interface
- CHANNELS, 4: number of independent channels (1..16).
- CNT_W, 29: width of period/high-time counters.
- CH_W, max(1, clog2(CHANNELS)): channel-select width.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  one-cycle write strobe.
- cfg_ch  in  CH_W  target channel; values >= CHANNELS are ignored.
- cfg_period  in  CNT_W  period P in clk cycles; must be >= 2.
- cfg_high  in  CNT_W  high time H in clk cycles.
- cfg_count  in  16  burst length in periods; 0 = continuous.
- en  in  CHANNELS  per-channel enable (level).
- clk_out  out  CHANNELS  generated clocks/pulses (registered).
- per_stb  out  CHANNELS  one-cycle strobe at each period start.
- done_stb  out  CHANNELS  one-cycle strobe when a burst finishes.
- busy  out  CHANNELS  1 while the channel is in RUN.
- cfg_err  out  1  one-cycle strobe when a write is rejected.

## Operation
- Each channel has shadow regs (P_s, H_s, N_s), a pending flag, active regs (P_a, H_a, N_a), cnt[CNT_W-1:0], rem[15:0], and a state in {IDLE, RUN, DONE}.
- Reset: P_a=0, H_a=0, N_a=0, no pending write, IDLE. All outputs are 0.
- Write acceptance:
  - If cfg_period < 2, the write is rejected: cfg_err=1 the next cycle and all registers are unchanged.
  - Otherwise the shadow regs are loaded and pending is set.
  - A second write before the update is applied overwrites the shadow regs.
- Applying a pending update:
  - IDLE or DONE: applied on the following edge. DONE then goes to RUN with cnt=0 and rem=N.
  - RUN: applied at the next wrap, when cnt == P_a-1. rem reloads to N_s at that point.
- State transitions (rst has highest priority, then en):
  - en[i]=0: go to IDLE with cnt=0 and rem=N_a. Active regs are retained.
  - IDLE to RUN: en[i]=1 and P_a >= 2. Start with cnt=0 and rem=N_a.
  - In RUN, cnt increments each cycle and wraps to 0 after P_a-1.
  - RUN to DONE: at a wrap when N_a != 0 and rem == 1. Otherwise, on a wrap with N_a != 0, decrement rem.
  - DONE persists until en falls or an accepted write arrives for that channel.
- Outputs in RUN:
  - clk_out follows cnt < H_a, so H_a=0 gives constant low and H_a >= P_a gives constant high.
  - per_stb follows cnt == 0.
  - In IDLE and DONE, clk_out=0 and per_stb=0.
- Unsigned compare at CNT_W bits; no arithmetic overflow, because cnt never exceeds P_a-1.
- 50% duty clock at f_clk/(2M): P=2M, H=M, count=0.

## Timing
- All outputs are registered, one cycle behind the internal cnt/state.
- Enable: en sampled high at edge k gives cnt=0 after edge k. clk_out (if H_a>0) and per_stb are 1 after edge k+1. busy=1 after edge k.
- Period is exactly P_a cycles between per_stb pulses, with H_a high cycles.
- Burst end: the last wrap edge w gives DONE and busy=0 after w. clk_out=0 and done_stb=1 after w+1.
- en falling at edge k: clk_out=0 and busy=0 after edge k+1 at the latest, with no partial-period extension.
- Write during a RUN wrap cycle: the captured write is applied at the following wrap, not the current one.
- cfg_we and en falling in the same cycle on the same channel: shadow is captured, the channel goes IDLE, and active is updated on the next edge.
- rst mid-burst: all outputs are 0 after the edge and all channels are IDLE with P_a=0.

## Test plan
- Continuous: ch0 with P=4, H=2, count=0, then en[0]=1. Expect clk_out[0] = 1,1,0,0 repeating and per_stb[0] every 4 cycles; other channels stay 0.
- Burst: ch1 with P=5, H=1, count=3, then en[1]=1. Expect exactly 3 one-cycle highs 5 cycles apart, one done_stb[1] pulse, busy[1] low afterwards, and no further pulses.
- Glitch-free update: ch0 running P=4, H=2; write P=6, H=3 mid-period. Expect the current period to complete as 4 cycles (2 high) and the next periods to be 6 cycles (3 high).
- Rejected write: cfg_period=1 to ch2. Expect cfg_err=1 for one cycle and ch2 behaviour unchanged.
- Enable/reset abort: drop en[0] mid-high. Expect clk_out[0]=0 next cycle; on re-enable, a full H-cycle high after 2 edges. Assert rst mid-burst on ch1. Expect all outputs 0, and ch1 does not restart until reconfigured.
- Edge duties: H=0 gives constant low with per_stb every P; H=7 with P=5 gives constant high with per_stb every 5.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/pulse generator: per-channel period, high time and
// burst count, with shadowed configuration that takes effect only at a period boundary.

module clk_div_ch #(
  parameter int CNT_W = 29
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_period,
  input  logic [CNT_W-1:0] wr_high,
  input  logic [15:0]      wr_count,
  input  logic             en,
  output logic             clk_out,
  output logic             per_stb,
  output logic             done_stb,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] p_s, h_s, p_a, h_a, cnt;
  logic [15:0]      n_s, n_a, rem;
  logic             pend, done_p;
  logic [CNT_W-1:0] np, nh;
  logic [15:0]      nn;
  logic             wrap;

  // Values the channel will run with once a pending write is folded in
  assign np   = pend ? p_s : p_a;
  assign nh   = pend ? h_s : h_a;
  assign nn   = pend ? n_s : n_a;
  assign wrap = (cnt == p_a - CNT_W'(1));
  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      p_s      <= '0;
      h_s      <= '0;
      n_s      <= '0;
      p_a      <= '0;
      h_a      <= '0;
      n_a      <= '0;
      cnt      <= '0;
      rem      <= '0;
      pend     <= 1'b0;
      done_p   <= 1'b0;
      clk_out  <= 1'b0;
      per_stb  <= 1'b0;
      done_stb <= 1'b0;
    end else begin
      done_p <= 1'b0;
      case (state)
        IDLE: begin
          p_a  <= np;
          h_a  <= nh;
          n_a  <= nn;
          pend <= 1'b0;
          cnt  <= '0;
          rem  <= nn;
          if (en && np >= CNT_W'(2)) state <= RUN;
        end
        RUN: begin
          if (!en) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= n_a;
          end else if (wrap) begin
            cnt <= '0;
            if (pend) begin
              p_a  <= p_s;
              h_a  <= h_s;
              n_a  <= n_s;
              rem  <= n_s;
              pend <= 1'b0;
            end else if (n_a != 16'd0) begin
              if (rem == 16'd1) begin
                state  <= DONE;
                done_p <= 1'b1;
              end else begin
                rem <= rem - 16'd1;
              end
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (!en) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= n_a;
          end else if (pend) begin
            p_a   <= p_s;
            h_a   <= h_s;
            n_a   <= n_s;
            rem   <= n_s;
            pend  <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
      // A new write always lands in shadow and outranks the pending clear above
      if (wr) begin
        p_s  <= wr_period;
        h_s  <= wr_high;
        n_s  <= wr_count;
        pend <= 1'b1;
      end
      clk_out  <= (state == RUN) && (cnt < h_a);
      per_stb  <= (state == RUN) && (cnt == '0);
      done_stb <= done_p;
    end
  end
endmodule

module clk_div_multi #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 29,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_high,
  input  logic [15:0]         cfg_count,
  input  logic [CHANNELS-1:0] en,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] per_stb,
  output logic [CHANNELS-1:0] done_stb,
  output logic [CHANNELS-1:0] busy,
  output logic                cfg_err
);
  logic per_ok;
  assign per_ok = (cfg_period >= CNT_W'(2));

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic wr;
    assign wr = cfg_we && (int'(cfg_ch) == i) && per_ok;
    clk_div_ch #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr),
      .wr_period(cfg_period),
      .wr_high  (cfg_high),
      .wr_count (cfg_count),
      .en       (en[i]),
      .clk_out  (clk_out[i]),
      .per_stb  (per_stb[i]),
      .done_stb (done_stb[i]),
      .busy     (busy[i])
    );
  end

  // Out-of-range channel selects are silently dropped, not flagged
  always_ff @(posedge clk) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= cfg_we && (int'(cfg_ch) < CHANNELS) && !per_ok;
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: continuous, burst, shadow update, reject, abort, duty edges.

module tb_clk_div_multi;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [28:0] cfg_period = '0;
  logic [28:0] cfg_high = '0;
  logic [15:0] cfg_count = '0;
  logic [3:0]  en = '0;
  logic [3:0]  clk_out, per_stb, done_stb, busy;
  logic        cfg_err;

  int checks = 0;
  int failures = 0;

  clk_div_multi #(.CHANNELS(4), .CNT_W(29)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
    .cfg_high(cfg_high), .cfg_count(cfg_count), .en(en), .clk_out(clk_out),
    .per_stb(per_stb), .done_stb(done_stb), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input int ch, input int p, input int h, input int n);
    cfg_ch = 2'(ch); cfg_period = 29'(p); cfg_high = 29'(h); cfg_count = 16'(n);
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({clk_out, per_stb, done_stb, busy, cfg_err} !== 17'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {clk_out, per_stb, done_stb, busy, cfg_err});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_continuous();
    write_cfg(0, 4, 2, 0);
    tick();
    en[0] = 1'b1;
    tick();
    checks++;
    if (busy[0] !== 1'b1 || clk_out[0] !== 1'b0) begin
      failures++;
      $display("FAIL cont_start busy=%b clk=%b want busy=1 clk=0", busy[0], clk_out[0]);
    end
    for (int j = 1; j <= 12; j++) begin
      tick();
      checks++;
      if (clk_out[0] !== (((j-1) % 4) < 2) || per_stb[0] !== (((j-1) % 4) == 0) || clk_out[3:1] !== 3'b0) begin
        failures++;
        $display("FAIL cont_cyc%0d clk=%b per=%b others=%b want clk=%b per=%b others=0",
                 j, clk_out[0], per_stb[0], clk_out[3:1], ((j-1) % 4) < 2, ((j-1) % 4) == 0);
      end
    end
  endtask

  task automatic test_glitch_free();
    logic ec, ep;
    en[0] = 1'b0; tick();
    en[0] = 1'b1; tick();
    tick();
    checks++;
    if (clk_out[0] !== 1'b1 || per_stb[0] !== 1'b1) begin
      failures++;
      $display("FAIL upd_first clk=%b per=%b want 1 1", clk_out[0], per_stb[0]);
    end
    write_cfg(0, 6, 3, 0);
    checks++;
    if (clk_out[0] !== 1'b1 || per_stb[0] !== 1'b0) begin
      failures++;
      $display("FAIL upd_second clk=%b per=%b want 1 0", clk_out[0], per_stb[0]);
    end
    for (int j = 3; j <= 16; j++) begin
      tick();
      if (j < 5) begin ec = 1'b0; ep = 1'b0; end
      else begin ec = ((j-5) % 6) < 3; ep = ((j-5) % 6) == 0; end
      checks++;
      if (clk_out[0] !== ec || per_stb[0] !== ep) begin
        failures++;
        $display("FAIL upd_cyc%0d clk=%b per=%b want clk=%b per=%b", j, clk_out[0], per_stb[0], ec, ep);
      end
    end
  endtask

  task automatic test_burst();
    logic ep;
    int pulses = 0;
    write_cfg(1, 5, 1, 3);
    tick();
    en[1] = 1'b1;
    tick();
    for (int j = 1; j <= 25; j++) begin
      tick();
      ep = (j <= 15) && (((j-1) % 5) == 0);
      if (clk_out[1]) pulses++;
      checks++;
      if (clk_out[1] !== ep || per_stb[1] !== ep || done_stb[1] !== (j == 16) || busy[1] !== (j <= 14)) begin
        failures++;
        $display("FAIL burst_cyc%0d clk=%b per=%b done=%b busy=%b want %b %b %b %b",
                 j, clk_out[1], per_stb[1], done_stb[1], busy[1], ep, ep, j == 16, j <= 14);
      end
    end
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL burst_pulses got=%0d want=3", pulses);
    end
  endtask

  task automatic test_reject();
    write_cfg(2, 3, 1, 0);
    tick();
    write_cfg(2, 1, 5, 0);
    checks++;
    if (cfg_err !== 1'b1) begin
      failures++;
      $display("FAIL reject_err got=%b want=1", cfg_err);
    end
    tick();
    checks++;
    if (cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL reject_err_clear got=%b want=0", cfg_err);
    end
    en[2] = 1'b1;
    tick();
    for (int j = 1; j <= 9; j++) begin
      tick();
      checks++;
      if (clk_out[2] !== (((j-1) % 3) == 0) || per_stb[2] !== (((j-1) % 3) == 0)) begin
        failures++;
        $display("FAIL reject_keep_cyc%0d clk=%b per=%b want %b", j, clk_out[2], per_stb[2], ((j-1) % 3) == 0);
      end
    end
    en[2] = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    en[0] = 1'b0; tick();
    en[0] = 1'b1; tick();
    tick(); tick();
    en[0] = 1'b0;
    tick();
    checks++;
    if (busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy got=%b want=0", busy[0]);
    end
    tick();
    checks++;
    if (clk_out[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_clk got=%b want=0", clk_out[0]);
    end
    en[0] = 1'b1;
    tick();
    checks++;
    if (busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL reen_busy got=%b want=1", busy[0]);
    end
    for (int j = 1; j <= 6; j++) begin
      tick();
      checks++;
      if (clk_out[0] !== (j <= 3) || per_stb[0] !== (j == 1)) begin
        failures++;
        $display("FAIL reen_cyc%0d clk=%b per=%b want %b %b", j, clk_out[0], per_stb[0], j <= 3, j == 1);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    write_cfg(1, 5, 1, 3);
    tick(); tick(); tick();
    checks++;
    if (busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_busy got=%b want=1", busy[1]);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({clk_out, per_stb, done_stb, busy, cfg_err} !== 17'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%h want=0", {clk_out, per_stb, done_stb, busy, cfg_err});
    end
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      checks++;
      if (busy[1:0] !== 2'b0 || clk_out[1:0] !== 2'b0 || per_stb[1:0] !== 2'b0) begin
        failures++;
        $display("FAIL rst_no_restart_cyc%0d busy=%b clk=%b per=%b want 0", j, busy[1:0], clk_out[1:0], per_stb[1:0]);
      end
    end
    write_cfg(1, 5, 1, 3);
    tick();
    checks++;
    if (busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL rst_reconfig_busy got=%b want=1", busy[1]);
    end
    en[1:0] = 2'b00;
    tick();
  endtask

  task automatic test_edge_duty();
    write_cfg(3, 3, 0, 0);
    tick();
    en[3] = 1'b1;
    tick();
    for (int j = 1; j <= 9; j++) begin
      tick();
      checks++;
      if (clk_out[3] !== 1'b0 || per_stb[3] !== (((j-1) % 3) == 0)) begin
        failures++;
        $display("FAIL h0_cyc%0d clk=%b per=%b want 0 %b", j, clk_out[3], per_stb[3], ((j-1) % 3) == 0);
      end
    end
    en[3] = 1'b0;
    tick();
    write_cfg(3, 5, 7, 0);
    tick();
    en[3] = 1'b1;
    tick();
    for (int j = 1; j <= 10; j++) begin
      tick();
      checks++;
      if (clk_out[3] !== 1'b1 || per_stb[3] !== (((j-1) % 5) == 0)) begin
        failures++;
        $display("FAIL hbig_cyc%0d clk=%b per=%b want 1 %b", j, clk_out[3], per_stb[3], ((j-1) % 5) == 0);
      end
    end
    en[3] = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_glitch_free();
    test_burst();
    test_reject();
    test_abort();
    test_reset_mid_burst();
    test_edge_duty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
